// File: rtl/bram_port_initiator.sv
// bram_port_initiator
//
// Request/response front-end for one port of a true dual-port byte-enable
// block RAM. Clients issue valid/ready read and write requests; at most one
// RAM operation is issued per cycle. Read data is captured one cycle after
// issue and returned in order through a small response FIFO with
// backpressure, so clients never deal with RAM latency or output hold.
//
// Optional build macro:
//   BRAM_INIT_CLEAR_EN - after reset, sweep the whole RAM with zeros
//                        (2^ADDR_WIDTH cycles, BUSY=1) before accepting
//                        requests. Undefined: no sweep, BUSY tied low.
//
// Parameters:
//   ADDR_WIDTH  RAM word address width (must match the attached RAM)
//   DATA_WIDTH  word width, multiple of 8
//   BE_WIDTH    byte-enable width, DATA_WIDTH/8
//   RESP_DEPTH  response FIFO entries (>=2; >=3 sustains one read per cycle)
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY        request handshake
//   REQ_WE/ADDR/DATA/BE        request fields (1=write, 0=read)
//   RESP_VALID/READY/DATA      in-order read responses
//   RAM_DI/ADDR/WE/RE/BE       drive the RAM port
//   RAM_DO                     registered RAM read data (held while RE=0)
//   BUSY                       init sweep in progress
module bram_port_initiator #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 8,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RESP_DEPTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    input  logic [BE_WIDTH-1:0]   REQ_BE,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  RAM_WE,
    output logic                  RAM_RE,
    output logic [BE_WIDTH-1:0]   RAM_BE,
    input  logic [DATA_WIDTH-1:0] RAM_DO,
    output logic                  BUSY
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RESP_DEPTH);

    // Elaboration-time parameter sanity.
    generate
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
            $error("DATA_WIDTH must be a multiple of 8");
        end
        if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be_width
            $error("BE_WIDTH must equal DATA_WIDTH/8");
        end
        if (RESP_DEPTH < 2) begin : g_bad_depth
            $error("RESP_DEPTH must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Run/clear control
    // ------------------------------------------------------------------
    logic in_run;

`ifdef BRAM_INIT_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg, clr_addr_next;
    logic                    clearing;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_addr_next = clr_addr_reg + ADDR_WIDTH'(1);
                if (clr_addr_reg == CLR_LAST) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign clearing = (state_reg == ST_CLEAR);
    assign in_run   = (state_reg == ST_RUN);
    assign BUSY     = clearing;
`else
    assign in_run = 1'b1;
    assign BUSY   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Credit accounting and issue
    // ------------------------------------------------------------------
    logic                  inflight_reg, inflight_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      credits_used;
    logic                  accept;
    logic                  rd_issue;
    logic                  wr_issue;
    logic                  capture;
    logic                  pop;
    logic [BE_WIDTH-1:0]   be_gated;

    // Every buffered or in-flight read holds one response slot; a new request
    // may only go out if a slot is guaranteed, which keeps the FIFO from
    // ever overflowing. RST_N gates ready so nothing is accepted while the
    // reset is held, even though the state registers already read RUN.
    assign credits_used = count_reg + CNT_W'(inflight_reg);
    assign REQ_READY    = RST_N && in_run && (credits_used < DEPTH_CNT);

    assign accept   = REQ_VALID && REQ_READY;
    assign rd_issue = accept && !REQ_WE;
    assign wr_issue = accept && REQ_WE;

    // Byte enables only reach the RAM on writes.
    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_be
            assign be_gated[gi] = REQ_BE[gi] & REQ_WE;
        end
    endgenerate

    always_comb begin
        RAM_ADDR = REQ_ADDR;
        RAM_DI   = REQ_DATA;
        RAM_BE   = be_gated;
        RAM_WE   = wr_issue;
        RAM_RE   = rd_issue;
`ifdef BRAM_INIT_CLEAR_EN
        if (clearing) begin
            RAM_ADDR = clr_addr_reg;
            RAM_DI   = '0;
            RAM_BE   = '1;
            RAM_WE   = RST_N;
            RAM_RE   = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // RAM_DO is valid the cycle after a read issue; inflight marks that cycle.
    assign capture    = inflight_reg;
    assign RESP_VALID = (count_reg != '0);
    assign pop        = RESP_VALID && RESP_READY;

    always_comb begin
        inflight_next = rd_issue;
        wr_ptr_next   = capture ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next   = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next    = count_reg;
        case ({capture, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            inflight_reg <= inflight_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Data storage carries no reset; validity is tracked by count_reg alone.
    // The head entry is read combinationally so a response is presented the
    // cycle after capture.
    logic [DATA_WIDTH-1:0] resp_mem [RESP_DEPTH];

    always_ff @(posedge CLK) begin
        if (capture) begin
            resp_mem[wr_ptr_reg] <= RAM_DO;
        end
    end

    assign RESP_DATA = resp_mem[rd_ptr_reg];

endmodule

// File: tb/tb_bram_port_initiator.sv
module tb_bram_port_initiator;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RD = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_DATA = '0;
    logic [BW-1:0] REQ_BE = '0;
    logic          RESP_VALID;
    logic          RESP_READY = 1'b0;
    logic [DW-1:0] RESP_DATA;
    logic [DW-1:0] RAM_DI;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_WE;
    logic          RAM_RE;
    logic [BW-1:0] RAM_BE;
    logic [DW-1:0] RAM_DO;
    logic          BUSY;

    bram_port_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .RESP_DEPTH(RD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_BE(REQ_BE),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
        .RAM_DI(RAM_DI), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE),
        .RAM_BE(RAM_BE), .RAM_DO(RAM_DO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Behavioural RAM port: registered read output held while RE=0.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_do = '0;
    bit            ram_loaded = 1'b0;
    assign RAM_DO = ram_do;

    always @(posedge CLK) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (RAM_WE)
                for (int b = 0; b < BW; b++)
                    if (RAM_BE[b]) ram_mem[RAM_ADDR][8*b +: 8] <= RAM_DI[8*b +: 8];
            if (RAM_RE) ram_do <= ram_mem[RAM_ADDR];
        end
    end

    // Scoreboard and checking
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mon_exp;
    int n_checks = 0;
    int n_pass   = 0;
    bit rr_random = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
        if (rr_random) RESP_READY = 1'($urandom_range(0, 1));
    endtask

    // mode: 0 = expect no response, 1 = expect reference model, 2 = expect exp_in
    task automatic send(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BW-1:0] be, input int mode, input logic [DW-1:0] exp_in,
                        output int waited);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_DATA = data; REQ_BE = be;
        waited = 0;
        for (int w = 0; w < 64; w++) begin
            #1;
            if (REQ_READY) begin
                if (we) begin
                    check("wr_ram_we", 32'(RAM_WE), 32'd1);
                    check("wr_ram_addr", 32'(RAM_ADDR), 32'(addr));
                    for (int b = 0; b < BW; b++)
                        if (be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
                    $display("req wr addr=%0d data=%08h be=%b", addr, data, be);
                end else begin
                    check("rd_ram_re", 32'(RAM_RE), 32'd1);
                    check("rd_ram_be", 32'(RAM_BE), 32'd0);
                    if (mode == 1) exp_q.push_back(ref_mem[addr]);
                    else if (mode == 2) exp_q.push_back(exp_in);
                    $display("req rd addr=%0d", addr);
                end
                tick();
                REQ_VALID = 1'b0;
                return;
            end
            waited++;
            tick();
        end
        check("accept_timeout", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
        int w;
        send(1'b1, addr, data, be, 1, '0, w);
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        int w;
        send(1'b0, addr, '0, 4'hF, 1, '0, w);
    endtask

    task automatic rd_exp(input logic [AW-1:0] addr, input logic [DW-1:0] e);
        int w;
        send(1'b0, addr, '0, 4'hF, 2, e, w);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_sweep();
`ifdef BRAM_INIT_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            check("sweep_busy", 32'(BUSY), 32'd1);
            check("sweep_not_ready", 32'(REQ_READY), 32'd0);
            tick();
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
`endif
        #1;
        check("run_busy", 32'(BUSY), 32'd0);
        check("run_ready", 32'(REQ_READY), 32'd1);
        tick();
    endtask

    // Response monitor: compares each dequeued response against the scoreboard.
    always @(negedge CLK) begin
        #1;
        if (!RST_N) begin
            exp_q.delete();
        end else if (RESP_VALID && RESP_READY) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(RESP_VALID), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("resp data=%08h exp=%08h", RESP_DATA, mon_exp);
                check("resp_data", RESP_DATA, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waited;
        logic [DW-1:0] exp7;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_req_ready", 32'(REQ_READY), 32'd0);
        check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
        check("rst_ram_we", 32'(RAM_WE), 32'd0);
        check("rst_ram_re", 32'(RAM_RE), 32'd0);
`ifdef BRAM_INIT_CLEAR_EN
        check("rst_busy", 32'(BUSY), 32'd1);
`else
        check("rst_busy", 32'(BUSY), 32'd0);
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        RESP_READY = 1'b1;
        wait_sweep();
`ifdef BRAM_INIT_CLEAR_EN
        rd_exp(4'd0, 32'h0000_0000);
        rd_exp(4'd15, 32'h0000_0000);
        drain("clear_drain");
`endif

        // Write then read-after-write, 2-cycle latency
        wr(4'd3, 32'hDEAD_BEEF, 4'hF);
        rd_exp(4'd3, 32'hDEAD_BEEF);
        #1;
        check("t1_valid_t1", 32'(RESP_VALID), 32'd0);
        @(negedge CLK);
        #1;
        check("t1_valid_t2", 32'(RESP_VALID), 32'd1);
        check("t1_data", RESP_DATA, 32'hDEAD_BEEF);
        tick();
        drain("t1_drain");

        // Byte-enable merge
        wr(4'd5, 32'h1122_3344, 4'hF);
        wr(4'd5, 32'hAABB_CCDD, 4'b0101);
        rd_exp(4'd5, 32'h11BB_33DD);
        drain("t2_drain");

        // Backpressure: 3 credits, fourth request stalls
        RESP_READY = 1'b0;
        rd(4'd0);
        rd(4'd1);
        rd(4'd2);
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_full_ready", 32'(REQ_READY), 32'd0);
            tick();
        end
        RESP_READY = 1'b1;
        send(1'b0, 4'd3, '0, 4'hF, 1, '0, waited);
        check("t3_accept_wait", 32'(waited), 32'd1);
        drain("t3_drain");

        // Streaming: 8 reads back to back
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'(8 + k); REQ_BE = 4'hF;
            end else begin
                REQ_VALID = 1'b0;
            end
            #1;
            if (k < 8) begin
                check("t4_ready", 32'(REQ_READY), 32'd1);
                if (REQ_READY) begin
                    exp_q.push_back(ref_mem[8 + k]);
                    $display("req rd addr=%0d", 8 + k);
                end
            end
            check("t4_valid", 32'(RESP_VALID), 32'((k >= 2) && (k <= 9)));
            tick();
        end
        REQ_VALID = 1'b0;
        drain("t4_drain");

        // Reset with a read in flight
        wr(4'd7, 32'h0707_0707, 4'hF);
        send(1'b0, 4'd7, '0, 4'hF, 0, '0, waited);
        RST_N = 1'b0;
        #1;
        check("t5_rst_ready", 32'(REQ_READY), 32'd0);
        check("t5_rst_valid", 32'(RESP_VALID), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t5_no_stale", 32'(RESP_VALID), 32'd0);
            tick();
        end
`ifdef BRAM_INIT_CLEAR_EN
        for (int i = 0; i < 40 && BUSY; i++) tick();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        exp7 = 32'h0000_0000;
`else
        exp7 = 32'h0707_0707;
`endif
        rd_exp(4'd7, exp7);
        drain("t5_drain");

        // Random mix with random backpressure
        rr_random = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), 1, '0, waited);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rr_random = 1'b0;
        RESP_READY = 1'b1;
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
